// File: rtl/exception_controller.sv
// Memory-stage exception controller: captures EPC/cause, flushes and stalls the
// pipeline, fetches the handler vector from data memory and redirects the PC.
module exception_controller #(
    parameter logic [31:0] VEC_INV  = 32'h0000_0004,
    parameter logic [31:0] VEC_PROT = 32'h0000_0002,
    parameter int          CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       i_exc_code,
    input  logic [31:0]      i_pc,
    input  logic [31:0]      i_vec_data,
    input  logic             i_vec_valid,
    output logic             o_vec_read,
    output logic [31:0]      o_vec_addr,
    output logic             o_flush,
    output logic             o_stall,
    output logic             o_pc_load,
    output logic [31:0]      o_pc_value,
    output logic [31:0]      o_epc,
    output logic [1:0]       o_cause,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_exc_count
);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        VEC_REQ,
        REDIRECT
    } state_t;

    localparam logic [1:0]       CAUSE_INV  = 2'b01;
    localparam logic [1:0]       CAUSE_PROT = 2'b10;
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_next;
    logic [31:0]      epc;
    logic [31:0]      handler;
    logic [1:0]       cause;
    logic [CNT_W-1:0] exc_count;
    logic             exc_accept;

    // Codes are only honoured in IDLE; anything seen mid-sequence belongs to a
    // flushed instruction.
    assign exc_accept = (state == IDLE) && (i_exc_code != 2'b00);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            epc       <= '0;
            cause     <= '0;
            exc_count <= '0;
            handler   <= '0;
        end else begin
            state <= state_next;
            if (exc_accept) begin
                epc   <= i_pc;
                cause <= (i_exc_code == CAUSE_PROT) ? CAUSE_PROT : CAUSE_INV;
                if (exc_count != '1)
                    exc_count <= exc_count + CNT_ONE;
            end
            if (state == VEC_REQ && i_vec_valid)
                handler <= i_vec_data;
        end
    end

    // NOTE: every combinational output gets a default first so no path through
    // the case statement can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:     if (exc_accept) state_next = FLUSH;
            FLUSH:    state_next = VEC_REQ;
            VEC_REQ:  if (i_vec_valid) state_next = REDIRECT;
            REDIRECT: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        o_vec_read = 1'b0;
        o_vec_addr = '0;
        o_flush    = 1'b0;
        o_stall    = 1'b0;
        o_pc_load  = 1'b0;
        o_pc_value = '0;
        o_busy     = 1'b0;
        unique case (state)
            FLUSH: begin
                o_flush = 1'b1;
                o_stall = 1'b1;
                o_busy  = 1'b1;
            end
            VEC_REQ: begin
                o_vec_read = 1'b1;
                o_vec_addr = (cause == CAUSE_PROT) ? VEC_PROT : VEC_INV;
                o_stall    = 1'b1;
                o_busy     = 1'b1;
            end
            REDIRECT: begin
                o_pc_load  = 1'b1;
                o_pc_value = handler;
                o_stall    = 1'b1;
                o_busy     = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_epc       = epc;
    assign o_cause     = cause;
    assign o_exc_count = exc_count;

endmodule

// File: tb/tb_exception_controller.sv
// Self-checking bench for exception_controller: directed paths plus randomized
// exceptions checked against a sequence-level reference timeline.
module tb_exception_controller;

    logic        clk;
    logic        rst;
    logic [1:0]  i_exc_code;
    logic [31:0] i_pc;
    logic [31:0] i_vec_data;
    logic        i_vec_valid;
    logic        o_vec_read;
    logic [31:0] o_vec_addr;
    logic        o_flush;
    logic        o_stall;
    logic        o_pc_load;
    logic [31:0] o_pc_value;
    logic [31:0] o_epc;
    logic [1:0]  o_cause;
    logic        o_busy;
    logic [7:0]  o_exc_count;

    exception_controller dut (
        .clk         (clk),
        .rst         (rst),
        .i_exc_code  (i_exc_code),
        .i_pc        (i_pc),
        .i_vec_data  (i_vec_data),
        .i_vec_valid (i_vec_valid),
        .o_vec_read  (o_vec_read),
        .o_vec_addr  (o_vec_addr),
        .o_flush     (o_flush),
        .o_stall     (o_stall),
        .o_pc_load   (o_pc_load),
        .o_pc_value  (o_pc_value),
        .o_epc       (o_epc),
        .o_cause     (o_cause),
        .o_busy      (o_busy),
        .o_exc_count (o_exc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int load_seen = 0;

    // Reference model: architectural registers only, updated per accepted exception.
    logic [31:0] m_epc;
    logic [1:0]  m_cause;
    int          m_count;

    always @(negedge clk) if (o_pc_load === 1'b1) load_seen++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input bit flush, input bit stall, input bit vread,
                             input logic [31:0] vaddr, input bit load, input logic [31:0] pcval,
                             input bit busy);
        chk({tag, ".flush"},    32'(o_flush),     32'(flush));
        chk({tag, ".stall"},    32'(o_stall),     32'(stall));
        chk({tag, ".vec_read"}, 32'(o_vec_read),  32'(vread));
        chk({tag, ".vec_addr"}, o_vec_addr,       vaddr);
        chk({tag, ".pc_load"},  32'(o_pc_load),   32'(load));
        chk({tag, ".pc_value"}, o_pc_value,       pcval);
        chk({tag, ".busy"},     32'(o_busy),      32'(busy));
        chk({tag, ".epc"},      o_epc,            m_epc);
        chk({tag, ".cause"},    32'(o_cause),     32'(m_cause));
        chk({tag, ".count"},    32'(o_exc_count), 32'(m_count));
    endtask

    // Starts at a negedge with the DUT idle; returns at the negedge of the first
    // idle cycle after REDIRECT so a following call tests first-IDLE acceptance.
    task automatic do_exc(input logic [1:0] code, input logic [31:0] pc, input int w,
                          input logic [31:0] data, input bit noise);
        logic [31:0] vaddr;
        check_out("idle", 0, 0, 0, 0, 0, 0, 0);
        i_exc_code = code;
        i_pc       = pc;
        m_epc      = pc;
        m_cause    = (code == 2'b10) ? 2'b10 : 2'b01;
        m_count    = (m_count < 255) ? m_count + 1 : 255;
        vaddr      = (m_cause == 2'b10) ? 32'h2 : 32'h4;
        @(negedge clk);
        check_out("flush", 1, 1, 0, 0, 0, 0, 1);
        i_exc_code = noise ? 2'b10 : 2'b00;
        i_pc       = pc ^ 32'h00F0_0000;
        for (int k = 0; k <= w; k++) begin
            @(negedge clk);
            check_out("vec_req", 0, 1, 1, vaddr, 0, 0, 1);
            i_exc_code  = noise ? ((k % 2 == 1) ? 2'b10 : 2'b11) : 2'b00;
            i_vec_valid = (k == w);
            i_vec_data  = (k == w) ? data : $urandom;
        end
        @(negedge clk);
        check_out("redirect", 0, 1, 0, 0, 1, data, 1);
        i_vec_valid = 1'b0;
        i_vec_data  = $urandom;
        i_exc_code  = noise ? 2'b01 : 2'b00;
        @(negedge clk);
        i_exc_code = 2'b00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int loads_before;
        rst         = 1'b1;
        i_exc_code  = 2'b00;
        i_pc        = 32'h0;
        i_vec_data  = 32'h0;
        i_vec_valid = 1'b0;
        m_epc       = '0;
        m_cause     = '0;
        m_count     = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check_out("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Stray valid in IDLE changes nothing
        i_vec_valid = 1'b1;
        i_vec_data  = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge clk);
            check_out("stray_valid", 0, 0, 0, 0, 0, 0, 0);
        end
        i_vec_valid = 1'b0;
        @(negedge clk);

        // Invalid-address path, immediate vector
        do_exc(2'b01, 32'h0000_0040, 0, 32'h0000_0200, 1'b0);
        // Protected path with 4-cycle memory wait
        do_exc(2'b10, 32'h0000_0100, 4, 32'h0000_0300, 1'b0);
        // Code 11 treated as invalid; codes during the sequence ignored
        do_exc(2'b11, 32'h0000_0AA0, 2, 32'h0000_0400, 1'b1);
        @(negedge clk);
        check_out("after_mask", 0, 0, 0, 0, 0, 0, 0);

        // Randomized exceptions
        for (int i = 0; i < 24; i++) begin
            logic [1:0] code;
            code = 2'($urandom_range(1, 3));
            do_exc(code, $urandom, int'($urandom_range(0, 5)), $urandom, 1'($urandom));
        end
        @(negedge clk);
        check_out("after_random", 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-sequence: abort in VEC_REQ with a valid pending
        loads_before = load_seen;
        i_exc_code   = 2'b01;
        i_pc         = 32'h0000_1234;
        @(negedge clk);
        i_exc_code = 2'b00;
        @(negedge clk);
        chk("mid_rst.in_vec_req", 32'(o_vec_read), 32'h1);
        rst         = 1'b1;
        i_vec_valid = 1'b1;
        i_vec_data  = 32'h0000_0777;
        m_epc       = '0;
        m_cause     = '0;
        m_count     = 0;
        @(negedge clk);
        rst         = 1'b0;
        i_vec_valid = 1'b0;
        check_out("mid_rst", 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_out("mid_rst_after", 0, 0, 0, 0, 0, 0, 0);
        chk("mid_rst.no_pc_load", 32'(load_seen - loads_before), 32'h0);

        // 300 back-to-back exceptions; count saturates at 255
        for (int i = 0; i < 300; i++)
            do_exc(2'($urandom_range(1, 3)), $urandom, 0, $urandom, 1'b0);
        check_out("saturated", 0, 0, 0, 0, 0, 0, 0);
        chk("saturated.count", 32'(o_exc_count), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
